// File: rtl/instr_fetch_pkg.sv
// Definitions shared by the fetch unit, the instruction register and the bench:
// word width, instruction field positions and fetch state encodings.
package instr_fetch_pkg;

  localparam int IR_WORD_WIDTH = 16;

  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 9;
  localparam int OP0_MSB    = 8;
  localparam int OP0_LSB    = 6;
  localparam int OP1_MSB    = 5;
  localparam int OP1_LSB    = 3;
  localparam int OP2_MSB    = 2;
  localparam int OP2_LSB    = 0;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_DRIVE = 3'd2,
    S_LOAD  = 3'd3,
    S_HOLD  = 3'd4
  } fetch_state_t;

  function automatic logic [OPCODE_MSB-OPCODE_LSB:0] ir_opcode(input logic [IR_WORD_WIDTH-1:0] w);
    return w[OPCODE_MSB:OPCODE_LSB];
  endfunction

  function automatic logic [OP0_MSB-OP0_LSB:0] ir_op0(input logic [IR_WORD_WIDTH-1:0] w);
    return w[OP0_MSB:OP0_LSB];
  endfunction

  function automatic logic [OP1_MSB-OP1_LSB:0] ir_op1(input logic [IR_WORD_WIDTH-1:0] w);
    return w[OP1_MSB:OP1_LSB];
  endfunction

  function automatic logic [OP2_MSB-OP2_LSB:0] ir_op2(input logic [IR_WORD_WIDTH-1:0] w);
    return w[OP2_MSB:OP2_LSB];
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Control, memory-handshake and status signals of the instruction fetch unit.
// The tri-state data bus is a separate net on the top level.
interface instr_fetch_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = 16
) ();

  logic                  fetch;
  logic                  jump;
  logic [ADDR_WIDTH-1:0] jump_addr;
  logic                  mem_req;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_ack;
  logic [WORD_WIDTH-1:0] mem_data;
  logic                  notLoadIR;
  logic [ADDR_WIDTH-1:0] pc;
  logic                  busy;
  logic                  done;

  modport master (
    input  fetch, jump, jump_addr, mem_ack, mem_data,
    output mem_req, mem_addr, notLoadIR, pc, busy, done
  );

  modport slave (
    output fetch, jump, jump_addr, mem_ack, mem_data,
    input  mem_req, mem_addr, notLoadIR, pc, busy, done
  );

endinterface

// File: rtl/instr_fetch_pc_counter.sv
// Program counter: asynchronous clear, parallel load for jumps, and
// increment that wraps naturally at the top of the address space.
module instr_fetch_pc_counter #(
  parameter int ADDR_WIDTH = 16
) (
  input  logic                  clock,
  input  logic                  notReset,
  input  logic                  load,
  input  logic [ADDR_WIDTH-1:0] load_value,
  input  logic                  inc,
  output logic [ADDR_WIDTH-1:0] pc
);

  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      pc <= '0;
    end else if (load) begin
      pc <= load_value;
    end else if (inc) begin
      pc <= pc + 1'b1;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: reads one word per fetch request over a req/ack
// handshake, then presents it on the shared bus and strobes notLoadIR.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int WORD_WIDTH = IR_WORD_WIDTH
) (
  input  logic                  clock,
  input  logic                  notReset,
  instr_fetch_if.master         bus,
  inout  wire  [WORD_WIDTH-1:0] data_bus
);

  fetch_state_t          state;
  fetch_state_t          state_nxt;
  logic [WORD_WIDTH-1:0] word;
  logic                  drive_en;
  logic                  issue;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic                  pc_load;
  logic                  pc_inc;
  logic                  ack_taken;

  instr_fetch_pc_counter #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_pc (
    .clock      (clock),
    .notReset   (notReset),
    .load       (pc_load),
    .load_value (bus.jump_addr),
    .inc        (pc_inc),
    .pc         (bus.pc)
  );

  always_comb begin
    state_nxt  = state;
    issue      = 1'b0;
    issue_addr = bus.pc;
    pc_load    = 1'b0;
    pc_inc     = 1'b0;
    ack_taken  = 1'b0;
    unique case (state)
      S_IDLE: begin
        pc_load = bus.jump;
        if (bus.fetch) begin
          issue      = 1'b1;
          issue_addr = bus.jump ? bus.jump_addr : bus.pc;
          state_nxt  = S_REQ;
        end
      end
      S_REQ: begin
        if (bus.mem_ack) begin
          ack_taken = 1'b1;
          pc_inc    = 1'b1;
          state_nxt = S_DRIVE;
        end
      end
      S_DRIVE: state_nxt = S_LOAD;
      S_LOAD:  state_nxt = S_HOLD;
      // A held fetch restarts straight from HOLD for one word every 4 cycles; jump is ignored here.
      S_HOLD: begin
        if (bus.fetch) begin
          issue     = 1'b1;
          state_nxt = S_REQ;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Every output is a register loaded from the next-state decode.
  always_ff @(posedge clock or negedge notReset) begin
    if (!notReset) begin
      state         <= S_IDLE;
      word          <= '0;
      drive_en      <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_addr  <= '0;
      bus.notLoadIR <= 1'b1;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
    end else begin
      state         <= state_nxt;
      bus.mem_req   <= (state_nxt == S_REQ);
      bus.notLoadIR <= (state_nxt != S_LOAD);
      bus.busy      <= (state_nxt != S_IDLE);
      bus.done      <= (state_nxt == S_HOLD);
      drive_en      <= (state_nxt == S_DRIVE) || (state_nxt == S_LOAD) || (state_nxt == S_HOLD);
      if (issue) begin
        bus.mem_addr <= issue_addr;
      end
      if (ack_taken) begin
        word <= bus.mem_data;
      end
    end
  end

  // drive_en clears asynchronously, so reset releases the bus immediately.
  assign data_bus = drive_en ? word : {WORD_WIDTH{1'bz}};

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: memory responder with programmable wait
// states, pulled-up data bus, instruction-register model and pc reference model.
module tb_instr_fetch;

  localparam int AW = 16;
  localparam int WW = 16;
  localparam logic [WW-1:0] BUS_IDLE = 16'hFFFF;

  logic clock = 1'b0;
  logic notReset = 1'b0;
  wire  [WW-1:0] data_bus;

  instr_fetch_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) ifc ();

  instr_fetch #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) dut (
    .clock    (clock),
    .notReset (notReset),
    .bus      (ifc),
    .data_bus (data_bus)
  );

  // Undriven bus reads as all ones; memory words never take that value.
  for (genvar g = 0; g < WW; g++) begin : g_pull
    pullup pu (data_bus[g]);
  end

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  logic [WW-1:0] mem [0:65535];
  logic [AW-1:0] pc_model = '0;
  int ack_delay = 0;
  int wait_cnt = 0;
  int cyc = 0;

  int ld_cnt, done_cnt, drv_cnt, bad_cnt;
  int done_cyc[$];
  logic [WW-1:0] ir_q[$];
  logic [WW-1:0] ir = '0;
  logic prev_req = 1'b0;
  logic [AW-1:0] prev_addr = '0;

  always @(posedge clock) cyc++;

  // Memory: acks after ack_delay wait cycles, noise on mem_data otherwise.
  always @(negedge clock) begin
    if (ifc.mem_req === 1'b1) begin
      if (wait_cnt >= ack_delay) begin
        ifc.mem_ack  = 1'b1;
        ifc.mem_data = mem[ifc.mem_addr];
      end else begin
        wait_cnt++;
        ifc.mem_ack  = 1'b0;
        ifc.mem_data = WW'($urandom);
      end
    end else begin
      wait_cnt     = 0;
      ifc.mem_ack  = 1'b0;
      ifc.mem_data = WW'($urandom);
    end
  end

  // Per-cycle observer: instruction register model plus protocol tallies.
  always @(negedge clock) begin
    logic drv;
    drv = (data_bus !== BUS_IDLE);
    if (drv) drv_cnt++;
    if (ifc.notLoadIR === 1'b0) begin
      ld_cnt++;
      ir = data_bus;
      ir_q.push_back(data_bus);
      if (!drv) bad_cnt++;
    end
    if (drv && ifc.mem_req === 1'b1) bad_cnt++;
    if (ifc.mem_req === 1'b1 && prev_req && ifc.mem_addr !== prev_addr) bad_cnt++;
    if (ifc.done === 1'b1) begin
      done_cnt++;
      done_cyc.push_back(cyc);
    end
    prev_req  = (ifc.mem_req === 1'b1);
    prev_addr = ifc.mem_addr;
  end

  task automatic step();
    @(negedge clock);
    #1;
  endtask

  task automatic clear_stats();
    ld_cnt = 0; done_cnt = 0; drv_cnt = 0; bad_cnt = 0;
    done_cyc.delete();
    ir_q.delete();
  endtask

  task automatic fetch_one(input bit use_jump, input logic [AW-1:0] jaddr, input int delay,
                           input bit jump_busy, input string name);
    logic [AW-1:0] exp_addr;
    logic [WW-1:0] exp_word;
    int budget;
    budget    = 0;
    ack_delay = delay;
    exp_addr  = use_jump ? jaddr : pc_model;
    exp_word  = mem[exp_addr];
    step();
    clear_stats();
    ifc.fetch = 1'b1; ifc.jump = use_jump; ifc.jump_addr = jaddr;
    step();
    ifc.fetch = 1'b0;
    ifc.jump  = jump_busy;
    ifc.jump_addr = ~jaddr;
    vectors++;
    if (ifc.mem_req !== 1'b1 || ifc.mem_addr !== exp_addr) begin
      miscompares++;
      $display("FAIL %s req/addr: got req=%b addr=%h, expected req=1 addr=%h", name, ifc.mem_req, ifc.mem_addr, exp_addr);
    end
    while (done_cnt == 0 && budget < 60) begin
      step();
      budget++;
    end
    ifc.jump = 1'b0;
    vectors++;
    if (budget != delay + 3) begin
      miscompares++;
      $display("FAIL %s latency: got %0d cycles to done, expected %0d", name, budget, delay + 3);
    end
    step();
    vectors++;
    if (ir !== exp_word) begin
      miscompares++;
      $display("FAIL %s ir: got %h expected %h", name, ir, exp_word);
    end
    vectors++;
    if (ifc.pc !== exp_addr + 16'd1) begin
      miscompares++;
      $display("FAIL %s pc: got %h expected %h", name, ifc.pc, exp_addr + 16'd1);
    end
    vectors++;
    if (ld_cnt != 1 || drv_cnt != 3 || done_cnt != 1 || bad_cnt != 0) begin
      miscompares++;
      $display("FAIL %s protocol: got load=%0d drive=%0d done=%0d bad=%0d, expected 1 3 1 0",
               name, ld_cnt, drv_cnt, done_cnt, bad_cnt);
    end
    vectors++;
    if (ifc.busy !== 1'b0 || data_bus !== BUS_IDLE) begin
      miscompares++;
      $display("FAIL %s idle: got busy=%b bus=%h, expected busy=0 bus=%h", name, ifc.busy, data_bus, BUS_IDLE);
    end
    pc_model = exp_addr + 16'd1;
  endtask

  task automatic test_reset();
    notReset = 1'b0;
    step(); step();
    vectors++;
    if (ifc.mem_req !== 1'b0 || ifc.mem_addr !== '0) begin
      miscompares++;
      $display("FAIL reset mem: got req=%b addr=%h, expected 0 0000", ifc.mem_req, ifc.mem_addr);
    end
    vectors++;
    if (ifc.notLoadIR !== 1'b1 || ifc.busy !== 1'b0 || ifc.done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset ctl: got nld=%b busy=%b done=%b, expected 1 0 0", ifc.notLoadIR, ifc.busy, ifc.done);
    end
    vectors++;
    if (ifc.pc !== '0 || data_bus !== BUS_IDLE) begin
      miscompares++;
      $display("FAIL reset pc/bus: got pc=%h bus=%h, expected 0000 %h", ifc.pc, data_bus, BUS_IDLE);
    end
    notReset = 1'b1;
    pc_model = '0;
    step();
  endtask

  task automatic test_basic();
    mem[0] = 16'b1010111_101_110_011;
    fetch_one(1'b0, '0, 0, 1'b0, "basic");
    vectors++;
    if (ir[15:9] !== 7'b1010111 || ir[8:6] !== 3'b101 || ir[5:3] !== 3'b110 || ir[2:0] !== 3'b011) begin
      miscompares++;
      $display("FAIL basic fields: got %b_%b_%b_%b expected 1010111_101_110_011", ir[15:9], ir[8:6], ir[5:3], ir[2:0]);
    end
  endtask

  task automatic test_wait_states();
    fetch_one(1'b0, '0, 5, 1'b0, "wait5");
  endtask

  task automatic test_jump_fetch();
    fetch_one(1'b1, 16'h1234, 1, 1'b1, "jump_fetch");
    vectors++;
    if (ifc.pc !== 16'h1235) begin
      miscompares++;
      $display("FAIL jump_fetch pc: got %h expected 1235", ifc.pc);
    end
  endtask

  task automatic test_wrap();
    step();
    ifc.jump = 1'b1; ifc.jump_addr = 16'hFFFF;
    step();
    ifc.jump = 1'b0;
    pc_model = 16'hFFFF;
    vectors++;
    if (ifc.pc !== 16'hFFFF || ifc.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL wrap jump: got pc=%h busy=%b expected FFFF 0", ifc.pc, ifc.busy);
    end
    fetch_one(1'b0, '0, 0, 1'b0, "wrap1");
    fetch_one(1'b0, '0, 0, 1'b0, "wrap2");
    vectors++;
    if (ifc.pc !== 16'h0001) begin
      miscompares++;
      $display("FAIL wrap pc: got %h expected 0001", ifc.pc);
    end
  endtask

  task automatic test_reset_mid();
    int budget;
    budget = 0;
    ack_delay = 0;
    step();
    ifc.fetch = 1'b1;
    step();
    ifc.fetch = 1'b0;
    while (ifc.notLoadIR !== 1'b0 && budget < 40) begin
      step();
      budget++;
    end
    vectors++;
    if (ifc.notLoadIR !== 1'b0 || data_bus === BUS_IDLE) begin
      miscompares++;
      $display("FAIL midreset reach load: got nld=%b bus=%h, expected 0 and driven", ifc.notLoadIR, data_bus);
    end
    #2 notReset = 1'b0;
    #1;
    vectors++;
    if (data_bus !== BUS_IDLE || ifc.notLoadIR !== 1'b1) begin
      miscompares++;
      $display("FAIL midreset async: got bus=%h nld=%b, expected %h 1", data_bus, ifc.notLoadIR, BUS_IDLE);
    end
    vectors++;
    if (ifc.pc !== '0 || ifc.busy !== 1'b0 || ifc.mem_req !== 1'b0) begin
      miscompares++;
      $display("FAIL midreset state: got pc=%h busy=%b req=%b, expected 0000 0 0", ifc.pc, ifc.busy, ifc.mem_req);
    end
    step();
    notReset = 1'b1;
    pc_model = '0;
    fetch_one(1'b0, '0, 2, 1'b0, "after_reset");
  endtask

  task automatic test_back_to_back();
    logic [AW-1:0] start;
    int budget;
    budget = 0;
    start = pc_model;
    ack_delay = 0;
    step();
    clear_stats();
    ifc.fetch = 1'b1;
    while (done_cnt < 3 && budget < 60) begin
      step();
      budget++;
    end
    ifc.fetch = 1'b0;
    step();
    vectors++;
    if (done_cnt != 3 || ld_cnt != 3 || drv_cnt != 9 || bad_cnt != 0) begin
      miscompares++;
      $display("FAIL b2b counts: got done=%0d load=%0d drive=%0d bad=%0d, expected 3 3 9 0", done_cnt, ld_cnt, drv_cnt, bad_cnt);
    end
    for (int i = 1; i < 3; i++) begin
      vectors++;
      if (done_cyc.size() != 3 || done_cyc[i] - done_cyc[i-1] != 4) begin
        miscompares++;
        $display("FAIL b2b spacing %0d: got %0d pulses, gap %0d, expected gap 4", i, done_cyc.size(),
                 (done_cyc.size() > i) ? done_cyc[i] - done_cyc[i-1] : -1);
      end
    end
    for (int i = 0; i < 3; i++) begin
      vectors++;
      if (ir_q.size() != 3 || ir_q[i] !== mem[start + AW'(i)]) begin
        miscompares++;
        $display("FAIL b2b word %0d: got %h expected %h", i, (ir_q.size() > i) ? ir_q[i] : 16'hxxxx, mem[start + AW'(i)]);
      end
    end
    vectors++;
    if (ifc.pc !== start + 16'd3 || ifc.busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b pc: got pc=%h busy=%b expected %h 0", ifc.pc, ifc.busy, start + 16'd3);
    end
    pc_model = start + 16'd3;
  endtask

  task automatic test_random();
    for (int i = 0; i < 8; i++) begin
      fetch_one(1'($urandom_range(0, 1)), AW'($urandom), int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), "random");
    end
  endtask

  initial begin
    ifc.fetch = 1'b0;
    ifc.jump = 1'b0;
    ifc.jump_addr = '0;
    for (int i = 0; i < 65536; i++) mem[i] = WW'($urandom_range(0, 32'hFFFE));
    clear_stats();
    test_reset();
    test_basic();
    test_wait_states();
    test_jump_fetch();
    test_wrap();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
